lab2_proc_hazard_ctrl: RTL

Pipeline hazard controller for the five-stage (F/D/X/M/W) processor. It shadows destination-register state for the X, M and W stages and computes the decode-stage stall and the operand bypass selects. It sits beside the decode logic: immediate generation and register-file read happen in D, and this block decides whether the D instruction may issue and where its operands come from. It owns the stall/valid propagation for X/M/W, so the datapath's pipeline-register enables are derived from its outputs.

---
 rtl/lab2_proc_hazard_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/lab2_proc_hazard_ctrl.sv
// Hazard controller for the F/D/X/M/W pipeline: tracks X/M/W destinations,
// produces the decode stall/issue and operand bypass selects, and the X/M/W stall chain.
module lab2_proc_hazard_ctrl #(
  parameter bit BYPASS_EN = 1'b1,
  parameter int AW        = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          val_D,
  input  logic          squash_D,
  input  logic          rs1_en_D,
  input  logic          rs2_en_D,
  input  logic [AW-1:0] rs1_D,
  input  logic [AW-1:0] rs2_D,
  input  logic          wen_D,
  input  logic [AW-1:0] waddr_D,
  input  logic          load_D,
  input  logic          ostall_X,
  input  logic          ostall_M,
  input  logic          ostall_W,
  output logic          stall_D,
  output logic          go_D,
  output logic [1:0]    byp1_sel,
  output logic [1:0]    byp2_sel,
  output logic          stall_X,
  output logic          stall_M,
  output logic          stall_W,
  output logic          val_X,
  output logic          val_M,
  output logic          val_W
);

  logic          val_x_reg, wen_x_reg, load_x_reg;
  logic [AW-1:0] waddr_x_reg;
  logic          val_m_reg, wen_m_reg, load_m_reg;
  logic [AW-1:0] waddr_m_reg;
  logic          val_w_reg, wen_w_reg, load_w_reg;
  logic [AW-1:0] waddr_w_reg;

  logic          eff_x, eff_m, eff_w;
  logic [1:0]    rs_en;
  logic [AW-1:0] rs [2];
  logic [1:0]    hit_x, hit_m, hit_w, haz;
  logic [1:0]    sel [2];
  logic          hazard;

  assign stall_W = ostall_W;
  assign stall_M = ostall_M | stall_W;
  assign stall_X = ostall_X | stall_M;

  // Writes to x0 are architecturally discarded, so they never create a dependence.
  assign eff_x = val_x_reg & wen_x_reg & (waddr_x_reg != '0);
  assign eff_m = val_m_reg & wen_m_reg & (waddr_m_reg != '0);
  assign eff_w = val_w_reg & wen_w_reg & (waddr_w_reg != '0);

  assign rs_en = {rs2_en_D, rs1_en_D};
  assign rs[0] = rs1_D;
  assign rs[1] = rs2_D;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      logic src_live;
      assign src_live  = rs_en[gi] & (rs[gi] != '0);
      assign hit_x[gi] = src_live & eff_x & (waddr_x_reg == rs[gi]);
      assign hit_m[gi] = src_live & eff_m & (waddr_m_reg == rs[gi]);
      assign hit_w[gi] = src_live & eff_w & (waddr_w_reg == rs[gi]);
      // Without bypass paths the RF is the only source, so any in-flight producer stalls.
      assign haz[gi] = BYPASS_EN ? (hit_x[gi] & load_x_reg)
                                 : (hit_x[gi] | hit_m[gi] | hit_w[gi]);
      assign sel[gi] = !BYPASS_EN ? 2'd0 :
                       hit_x[gi]  ? 2'd1 :
                       hit_m[gi]  ? 2'd2 :
                       hit_w[gi]  ? 2'd3 : 2'd0;
    end
  endgenerate

  assign hazard   = |haz;
  assign stall_D  = val_D & (stall_X | hazard);
  assign go_D     = val_D & ~stall_D & ~squash_D;
  assign byp1_sel = val_D ? sel[0] : 2'd0;
  assign byp2_sel = val_D ? sel[1] : 2'd0;

  assign val_X = val_x_reg;
  assign val_M = val_m_reg;
  assign val_W = val_w_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      val_x_reg   <= 1'b0;
      wen_x_reg   <= 1'b0;
      load_x_reg  <= 1'b0;
      waddr_x_reg <= '0;
      val_m_reg   <= 1'b0;
      wen_m_reg   <= 1'b0;
      load_m_reg  <= 1'b0;
      waddr_m_reg <= '0;
      val_w_reg   <= 1'b0;
      wen_w_reg   <= 1'b0;
      load_w_reg  <= 1'b0;
      waddr_w_reg <= '0;
    end else begin
      if (!stall_X) begin
        val_x_reg   <= go_D;
        wen_x_reg   <= wen_D;
        load_x_reg  <= load_D;
        waddr_x_reg <= waddr_D;
      end
      // A stage that advances while its upstream is held receives a bubble.
      if (!stall_M) begin
        val_m_reg   <= val_x_reg & ~stall_X;
        wen_m_reg   <= wen_x_reg;
        load_m_reg  <= load_x_reg;
        waddr_m_reg <= waddr_x_reg;
      end
      if (!stall_W) begin
        val_w_reg   <= val_m_reg & ~stall_M;
        wen_w_reg   <= wen_m_reg;
        load_w_reg  <= load_m_reg;
        waddr_w_reg <= waddr_m_reg;
      end
    end
  end

endmodule
